// File: rtl/ica_dca_sequencer.sv
// ICA/DCA instruction fetch and decode engine for one display plane.
// Fetches ICA per field and DCA per line, then decodes the shared command set.
package ica_dca_pkg;
    typedef struct packed {
        logic cm;
        logic mf1;
        logic mf2;
        logic ft1;
        logic ft2;
        logic strobe;
    } display_parameters_s;
endpackage

module ica_dca_sequencer
    import ica_dca_pkg::*;
#(
    parameter int UNIT_INDEX = 0,
    parameter int ADDR_W = 22,
    parameter int BURST_WORDS = 4,
    parameter int DCA_INSTR = 16,
    parameter logic [ADDR_W-1:0] ODD_ICA_START = 'h400,
    parameter logic [ADDR_W-1:0] EVEN_ICA_START = 'h404
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                field_start,
    input  logic                parity,
    input  logic                hblank,
    input  logic                dca_read,
    output logic [ADDR_W-1:0]   address,
    output logic                as,
    input  logic [15:0]         din,
    input  logic                burstdata_valid,
    input  logic                bus_ack,
    output logic [6:0]          register_adr,
    output logic [23:0]         register_data,
    output logic                register_write,
    output logic                reload_vsr,
    output logic [21:0]         vsr,
    output logic                irq,
    output display_parameters_s disp_params,
    output logic                dca_overrun
);

    localparam int IPB = BURST_WORDS / 2;
    localparam int LB  = $clog2(2 * BURST_WORDS);
    localparam int KW  = LB - 2;
    localparam int IB  = $clog2(IPB);
    localparam int IW  = $clog2(DCA_INSTR + IPB + 1);
    localparam int BCW = 6;

    // plane index carried for debug naming only
    localparam logic [31:0] UNIT_BITS = 32'(UNIT_INDEX);
    logic unused_unit;
    assign unused_unit = ^UNIT_BITS;

    typedef enum logic [2:0] {
        IDLE,
        ICA_RD_HI,
        ICA_RD_LO,
        ICA_ACK,
        ICA_GAP,
        DCA_RD_HI,
        DCA_RD_LO,
        DCA_ACK
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] ica_pointer;
    logic [ADDR_W-1:0] dca_pointer;
    logic [ADDR_W-1:0] next_line_pointer;
    logic              ica_ended;
    logic              dca_active;
    logic              fs_pend;
    logic              dca_req;
    logic [15:0]       hi_word;
    logic [31:0]       instr;
    logic              exec;
    logic [IW-1:0]     idx;
    logic [KW-1:0]     skip;
    logic [BCW-1:0]    bursts_left;

    logic              take_fs;
    logic              start_ica;
    logic              start_dca;
    logic              next_burst;
    logic              line_end;

    logic [3:0]        op;
    logic              is_cmd;
    logic              dec_stop;
    logic              dca_live;
    logic              burst_last;
    logic              in_range;
    logic [ADDR_W-1:0] imm;

    assign op       = instr[31:28];
    assign imm      = instr[ADDR_W-1:0];
    assign is_cmd   = exec && !instr[31];
    assign dec_stop = is_cmd && (op == 4'd0 || op == 4'd3 || op == 4'd5);
    // a stop decoded this cycle already ends the line
    assign dca_live = dca_active && !dec_stop;

    assign burst_last = (idx[IB-1:0] == IB'(IPB - 1));
    assign in_range   = (int'(idx) >= int'(skip)) &&
                        (int'(idx) < int'(skip) + DCA_INSTR);

    assign register_adr   = instr[30:24];
    assign register_data  = instr[23:0];
    assign vsr            = instr[21:0];
    assign register_write = exec && instr[31];
    assign reload_vsr     = is_cmd &&
                            (op == 4'd5 || (op == 4'd4 && ica_ended));
    assign irq            = is_cmd && op == 4'd6;

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // next state and per-cycle control strobes
    always_comb begin
        state_next = state;
        take_fs    = 1'b0;
        start_ica  = 1'b0;
        start_dca  = 1'b0;
        next_burst = 1'b0;
        line_end   = 1'b0;
        unique case (state)
            IDLE: begin
                if (fs_pend || field_start) begin
                    take_fs = 1'b1;
                end else if (!ica_ended && !hblank) begin
                    start_ica  = 1'b1;
                    state_next = ICA_RD_HI;
                end else if (dca_read || dca_req) begin
                    start_dca  = 1'b1;
                    state_next = DCA_RD_HI;
                end
            end
            ICA_RD_HI: if (burstdata_valid) state_next = ICA_RD_LO;
            ICA_RD_LO: if (burstdata_valid) state_next = ICA_ACK;
            ICA_ACK:   if (bus_ack) state_next = ICA_GAP;
            ICA_GAP:   state_next = IDLE;
            DCA_RD_HI: if (burstdata_valid) state_next = DCA_RD_LO;
            DCA_RD_LO: begin
                if (burstdata_valid)
                    state_next = burst_last ? DCA_ACK : DCA_RD_HI;
            end
            DCA_ACK: begin
                if (bus_ack) begin
                    if (bursts_left > BCW'(1) && dca_live) begin
                        next_burst = 1'b1;
                        state_next = DCA_RD_HI;
                    end else begin
                        line_end   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // bus, pointers, fetch datapath and command decode
    always_ff @(posedge clk) begin
        if (reset) begin
            address           <= '0;
            as                <= 1'b0;
            ica_pointer       <= parity ? ODD_ICA_START : EVEN_ICA_START;
            dca_pointer       <= '0;
            next_line_pointer <= '0;
            ica_ended         <= 1'b0;
            dca_active        <= 1'b0;
            fs_pend           <= 1'b0;
            dca_req           <= 1'b0;
            hi_word           <= '0;
            instr             <= '0;
            exec              <= 1'b0;
            idx               <= '0;
            skip              <= '0;
            bursts_left       <= '0;
            disp_params       <= '0;
            dca_overrun       <= 1'b0;
        end else begin
            exec               <= 1'b0;
            dca_overrun        <= 1'b0;
            disp_params.strobe <= 1'b0;

            if (take_fs)          fs_pend <= 1'b0;
            else if (field_start) fs_pend <= 1'b1;

            if (start_dca) begin
                dca_req <= 1'b0;
            end else if (dca_read) begin
                dca_req <= 1'b1;
                if (state != IDLE) dca_overrun <= 1'b1;
            end

            if (take_fs) begin
                ica_pointer <= parity ? ODD_ICA_START : EVEN_ICA_START;
                ica_ended   <= 1'b0;
                dca_active  <= 1'b0;
            end

            if (start_ica) begin
                as          <= 1'b1;
                address     <= ica_pointer;
                ica_pointer <= ica_pointer + ADDR_W'(4);
            end

            if (start_dca) begin
                as                <= 1'b1;
                address           <= {dca_pointer[ADDR_W-1:LB], LB'(0)};
                next_line_pointer <= dca_pointer + ADDR_W'(4 * DCA_INSTR);
                skip              <= dca_pointer[LB-1:2];
                idx               <= '0;
                bursts_left       <= BCW'(DCA_INSTR / IPB) +
                                     BCW'(dca_pointer[LB-1:2] != '0);
                dca_active        <= 1'b1;
            end

            if (state == ICA_ACK && bus_ack) as <= 1'b0;

            if (next_burst) begin
                address     <= address + ADDR_W'(2 * BURST_WORDS);
                bursts_left <= bursts_left - BCW'(1);
            end

            if (line_end) begin
                as          <= 1'b0;
                dca_pointer <= next_line_pointer;
            end

            if (burstdata_valid &&
                (state == ICA_RD_HI || state == DCA_RD_HI))
                hi_word <= din;

            if (burstdata_valid && state == ICA_RD_LO) begin
                instr <= {hi_word, din};
                exec  <= 1'b1;
            end

            if (burstdata_valid && state == DCA_RD_LO) begin
                idx <= idx + IW'(1);
                if (in_range && dca_live) begin
                    instr <= {hi_word, din};
                    exec  <= 1'b1;
                end
            end

            if (is_cmd) begin
                unique case (1'b1)
                    op == 4'd0: begin
                        ica_ended  <= 1'b1;
                        dca_active <= 1'b0;
                    end
                    op == 4'd2: begin
                        if (!ica_ended) dca_pointer <= imm;
                    end
                    op == 4'd3: begin
                        dca_pointer       <= imm;
                        next_line_pointer <= imm;
                        ica_ended         <= 1'b1;
                        dca_active        <= 1'b0;
                    end
                    op == 4'd4: ica_pointer <= imm;
                    op == 4'd5: begin
                        ica_ended  <= 1'b1;
                        dca_active <= 1'b0;
                    end
                    op == 4'd7: begin
                        if (instr[27]) begin
                            disp_params.cm     <= instr[4];
                            disp_params.mf1    <= instr[3];
                            disp_params.mf2    <= instr[2];
                            disp_params.ft1    <= instr[1];
                            disp_params.ft2    <= instr[0];
                            disp_params.strobe <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ica_dca_sequencer.sv
// Directed bench: two sequencers (4- and 8-word bursts) on behavioural buses.
// Memory returns register-write instructions carrying their own address.
module tb_ica_dca_sequencer;
    import ica_dca_pkg::*;

    logic clk;
    logic reset;
    logic field_start;
    logic parity;
    logic hblank;
    logic dca_read;

    logic [21:0]         addr_v [2];
    logic                as_v [2];
    logic [15:0]         din_v [2];
    logic                valid_v [2];
    logic                ack_v [2];
    logic [6:0]          radr_v [2];
    logic [23:0]         rdata_v [2];
    logic                rw_v [2];
    logic                rvsr_v [2];
    logic [21:0]         vsr_v [2];
    logic                irq_v [2];
    display_parameters_s dp_v [2];
    logic                ovr_v [2];

    logic [31:0] imem [logic [31:0]];
    logic [31:0] acc0 [$];
    logic [31:0] acc1 [$];
    logic [31:0] ex0 [$];
    logic [31:0] ex1 [$];
    int irq_n [2];
    int rvsr_n [2];
    int dp_n [2];
    int ovr_n [2];
    int bus_err [2];
    logic [21:0] vsr_last [2];

    int n_chk;
    int n_pass;
    int b0, b1, e0, e1, o0;

    ica_dca_sequencer #(.BURST_WORDS(4)) dut_a (
        .clk(clk), .reset(reset), .field_start(field_start),
        .parity(parity), .hblank(hblank), .dca_read(dca_read),
        .address(addr_v[0]), .as(as_v[0]), .din(din_v[0]),
        .burstdata_valid(valid_v[0]), .bus_ack(ack_v[0]),
        .register_adr(radr_v[0]), .register_data(rdata_v[0]),
        .register_write(rw_v[0]), .reload_vsr(rvsr_v[0]),
        .vsr(vsr_v[0]), .irq(irq_v[0]), .disp_params(dp_v[0]),
        .dca_overrun(ovr_v[0])
    );

    ica_dca_sequencer #(.BURST_WORDS(8)) dut_b (
        .clk(clk), .reset(reset), .field_start(field_start),
        .parity(parity), .hblank(hblank), .dca_read(dca_read),
        .address(addr_v[1]), .as(as_v[1]), .din(din_v[1]),
        .burstdata_valid(valid_v[1]), .bus_ack(ack_v[1]),
        .register_adr(radr_v[1]), .register_data(rdata_v[1]),
        .register_write(rw_v[1]), .reload_vsr(rvsr_v[1]),
        .vsr(vsr_v[1]), .irq(irq_v[1]), .disp_params(dp_v[1]),
        .dca_overrun(ovr_v[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (imem.exists(a)) return imem[a];
        return 32'h8000_0000 | {8'h00, a[23:0]};
    endfunction

    function automatic logic [31:0] at(input logic [31:0] q [$], input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_fs();
        field_start = 1'b1;
        tick(1);
        field_start = 1'b0;
    endtask

    task automatic pulse_dca();
        dca_read = 1'b1;
        tick(1);
        dca_read = 1'b0;
    endtask

    // 2 words for ICA addresses, a full burst elsewhere, then bus_ack
    task automatic bus_model(input int g, input int bw);
        logic [31:0] a;
        logic [31:0] w;
        int n;
        forever begin
            @(posedge clk);
            #1;
            if (as_v[g] === 1'b1) begin
                a = 32'(addr_v[g]);
                n = (a < 32'h800) ? 2 : bw;
                if (g == 0) acc0.push_back(a);
                else        acc1.push_back(a);
                for (int i = 0; i < n; i++) begin
                    if (as_v[g] !== 1'b1 || 32'(addr_v[g]) != a)
                        bus_err[g]++;
                    w = mem_word((a + 32'(2 * i)) & ~32'h3);
                    valid_v[g] = 1'b1;
                    din_v[g] = (i % 2 == 0) ? w[31:16] : w[15:0];
                    @(posedge clk);
                    #1;
                end
                valid_v[g] = 1'b0;
                if (as_v[g] !== 1'b1) bus_err[g]++;
                ack_v[g] = 1'b1;
                @(posedge clk);
                #1;
                ack_v[g] = 1'b0;
            end
        end
    endtask

    initial begin
        valid_v[0] = 1'b0;
        ack_v[0] = 1'b0;
        din_v[0] = '0;
        bus_model(0, 4);
    end

    initial begin
        valid_v[1] = 1'b0;
        ack_v[1] = 1'b0;
        din_v[1] = '0;
        bus_model(1, 8);
    end

    // record output strobes on the inactive edge
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            for (int g = 0; g < 2; g++) begin
                if (rw_v[g]) begin
                    if (g == 0) ex0.push_back({1'b0, radr_v[g], rdata_v[g]});
                    else        ex1.push_back({1'b0, radr_v[g], rdata_v[g]});
                end
                if (irq_v[g]) irq_n[g]++;
                if (rvsr_v[g]) begin
                    rvsr_n[g]++;
                    vsr_last[g] = vsr_v[g];
                end
                if (dp_v[g].strobe) dp_n[g]++;
                if (ovr_v[g]) ovr_n[g]++;
            end
        end
    end

    initial begin
        n_chk = 0;
        n_pass = 0;
        reset = 1'b1;
        parity = 1'b1;
        hblank = 1'b0;
        field_start = 1'b0;
        dca_read = 1'b0;
        imem[32'h400] = 32'h0000_0000;
        tick(3);

        @(negedge clk);
        check("rst_as", 32'(as_v[0]), 32'd0);
        check("rst_addr", 32'(addr_v[0]), 32'd0);
        check("rst_irq", 32'(irq_v[0]), 32'd0);
        check("rst_rw", 32'(rw_v[0]), 32'd0);
        check("rst_rvsr", 32'(rvsr_v[0]), 32'd0);
        check("rst_ovr", 32'(ovr_v[0]), 32'd0);
        check("rst_disp", 32'(dp_v[0]), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 1: first ICA fetch at odd start, STOP ends ICA
        for (int c = 0; c < 10 && as_v[0] !== 1'b1; c++) @(negedge clk);
        check("t1_as_up", 32'(as_v[0]), 32'd1);
        check("t1_addr", 32'(addr_v[0]), 32'h400);
        tick(40);
        check("t1_acc_cnt", 32'(acc0.size()), 32'd1);
        check("t1_as_idle", 32'(as_v[0]), 32'd0);

        // 2: register write, irq, disp params, ica jump, vsr reload stop
        imem[32'h400] = 32'h8011_2233;
        imem[32'h404] = 32'h6000_0000;
        imem[32'h408] = 32'h7800_001A;
        imem[32'h40C] = 32'h4000_0500;
        imem[32'h500] = 32'h2000_1000;
        imem[32'h504] = 32'h5012_3456;
        b0 = acc0.size();
        e0 = ex0.size();
        pulse_fs();
        tick(80);
        check("t2_rw_cnt", 32'(ex0.size() - e0), 32'd1);
        check("t2_rw_val", at(ex0, e0), 32'h0011_2233);
        check("t2_irq_cnt", 32'(irq_n[0]), 32'd1);
        check("t2_disp_cnt", 32'(dp_n[0]), 32'd1);
        check("t2_disp_val", 32'({dp_v[0].cm, dp_v[0].mf1, dp_v[0].mf2,
                                  dp_v[0].ft1, dp_v[0].ft2}), 32'h1A);
        check("t2_rvsr_cnt", 32'(rvsr_n[0]), 32'd1);
        check("t2_vsr", 32'(vsr_last[0]), 32'h12_3456);
        check("t2_acc_cnt", 32'(acc0.size() - b0), 32'd6);
        check("t2_jump", at(acc0, b0 + 4), 32'h500);
        check("t2_last", at(acc0, b0 + 5), 32'h504);

        // 3: aligned DCA line from 'h1000, 4-word bursts
        b0 = acc0.size();
        e0 = ex0.size();
        o0 = ovr_n[0];
        pulse_dca();
        tick(150);
        check("t3_bursts", 32'(acc0.size() - b0), 32'd8);
        check("t3_first", at(acc0, b0), 32'h1000);
        check("t3_lastb", at(acc0, b0 + 7), 32'h1038);
        check("t3_exec_cnt", 32'(ex0.size() - e0), 32'd16);
        check("t3_exec0", at(ex0, e0), 32'h1000);
        check("t3_exec15", at(ex0, e0 + 15), 32'h103C);
        check("t3_no_ovr", 32'(ovr_n[0] - o0), 32'd0);

        // 5: second request mid-line is latched and flagged
        b0 = acc0.size();
        e0 = ex0.size();
        o0 = ovr_n[0];
        pulse_dca();
        tick(3);
        pulse_dca();
        tick(250);
        check("t5_ovr", 32'(ovr_n[0] - o0), 32'd1);
        check("t5_bursts", 32'(acc0.size() - b0), 32'd16);
        check("t5_line1", at(acc0, b0), 32'h1040);
        check("t5_line2", at(acc0, b0 + 8), 32'h1080);
        check("t5_exec_cnt", 32'(ex0.size() - e0), 32'd32);
        check("t5_exec_last", at(ex0, e0 + 31), 32'h10BC);

        // 4: unaligned DCA pointer 'h1004 on both burst sizes
        imem[32'h400] = 32'h2000_1004;
        imem[32'h404] = 32'h0000_0000;
        pulse_fs();
        tick(40);
        b0 = acc0.size();
        b1 = acc1.size();
        e0 = ex0.size();
        e1 = ex1.size();
        pulse_dca();
        tick(200);
        check("t4b_bursts", 32'(acc1.size() - b1), 32'd5);
        check("t4b_first", at(acc1, b1), 32'h1000);
        check("t4b_lastb", at(acc1, b1 + 4), 32'h1040);
        check("t4b_exec_cnt", 32'(ex1.size() - e1), 32'd16);
        check("t4b_exec0", at(ex1, e1), 32'h1004);
        check("t4b_exec15", at(ex1, e1 + 15), 32'h1040);
        check("t4a_bursts", 32'(acc0.size() - b0), 32'd9);
        check("t4a_lastb", at(acc0, b0 + 8), 32'h1040);
        check("t4a_exec_cnt", 32'(ex0.size() - e0), 32'd16);
        check("t4a_exec0", at(ex0, e0), 32'h1004);
        check("t4a_exec15", at(ex0, e0 + 15), 32'h1040);

        // 6: field_start during an ICA access restarts at even start
        imem[32'h400] = 32'h0000_0000;
        imem[32'h404] = 32'h0000_0000;
        b0 = acc0.size();
        pulse_fs();
        for (int c = 0; c < 20 && as_v[0] !== 1'b1; c++) @(negedge clk);
        check("t6_as_up", 32'(as_v[0]), 32'd1);
        tick(1);
        parity = 1'b0;
        pulse_fs();
        tick(60);
        check("t6_acc_cnt", 32'(acc0.size() - b0), 32'd2);
        check("t6_first", at(acc0, b0), 32'h400);
        check("t6_restart", at(acc0, b0 + 1), 32'h404);
        check("bus_proto_a", 32'(bus_err[0]), 32'd0);
        check("bus_proto_b", 32'(bus_err[1]), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
